// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared types and constants for the instruction-decode stage:
//               format codes, opcode values, buffer states and the entry
//               record held by the stage's head and skid registers.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

  // Width of the PC field inside a stored entry (widest supported XLEN).
  localparam int c_PC_W = 64;

  // Instruction format codes as presented on the fmt output.
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_t;

  // Major opcodes, inst[6:0].
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  // Occupancy of the two-entry buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  // One decoded instruction. Register fields are kept at their native 5 bits
  // and the immediate at 32 bits; both are widened only at the stage outputs.
  typedef struct packed {
    logic [31:0]       inst;
    logic [c_PC_W-1:0] pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              rs1_en;
    logic              rs2_en;
    logic              rd_en;
    logic [31:0]       imm;
    fmt_t              fmt;
    logic              illegal;
  } dec_entry_t;

endpackage
`default_nettype wire

// File: rtl/decode_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_if
// Description : Fetch-side and decode-side handshake bundle of the decode
//               stage. slave = stage view, master = surrounding logic view.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [XLEN-1:0]  out_pc;
  logic [REG_W-1:0] rs1_sel;
  logic [REG_W-1:0] rs2_sel;
  logic [REG_W-1:0] rd_sel;
  logic             rs1_en;
  logic             rs2_en;
  logic             rd_en;
  logic [XLEN-1:0]  imm;
  logic [2:0]       fmt;
  logic             illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc,
           rs1_sel, rs2_sel, rd_sel, rs1_en, rs2_en, rd_en,
           imm, fmt, illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc,
           rs1_sel, rs2_sel, rd_sel, rs1_en, rs2_en, rd_en,
           imm, fmt, illegal
  );
endinterface
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational classifier: opcode -> format, register-field
//               enables, illegal flag and 32-bit sign-extended immediate.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] i_inst,
  output fmt_t        o_fmt,
  output logic [31:0] o_imm,
  output logic        o_rs1_en,
  output logic        o_rs2_en,
  output logic        o_rd_en,
  output logic        o_illegal
);

  // Opcode to instruction format.
  always_comb begin
    o_fmt = FMT_ILL;
    case (i_inst[6:0])
      c_OP_OP:                                       o_fmt = FMT_R;
      c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM:   o_fmt = FMT_I;
      c_OP_STORE:                                    o_fmt = FMT_S;
      c_OP_BRANCH:                                   o_fmt = FMT_B;
      c_OP_LUI, c_OP_AUIPC:                          o_fmt = FMT_U;
      c_OP_JAL:                                      o_fmt = FMT_J;
      default:                                       o_fmt = FMT_ILL;
    endcase
  end

  // Field enables and immediate by format; writes to x0 are not real writes.
  always_comb begin
    o_rs1_en  = 1'b0;
    o_rs2_en  = 1'b0;
    o_rd_en   = 1'b0;
    o_illegal = 1'b0;
    o_imm     = 32'd0;
    case (o_fmt)
      FMT_R: begin
        o_rs1_en = 1'b1;
        o_rs2_en = 1'b1;
        o_rd_en  = 1'b1;
      end
      FMT_I: begin
        o_rs1_en = 1'b1;
        o_rd_en  = 1'b1;
        o_imm    = {{20{i_inst[31]}}, i_inst[31:20]};
      end
      FMT_S: begin
        o_rs1_en = 1'b1;
        o_rs2_en = 1'b1;
        o_imm    = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      end
      FMT_B: begin
        o_rs1_en = 1'b1;
        o_rs2_en = 1'b1;
        o_imm    = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                    i_inst[30:25], i_inst[11:8], 1'b0};
      end
      FMT_U: begin
        o_rd_en = 1'b1;
        o_imm   = {i_inst[31:12], 12'd0};
      end
      FMT_J: begin
        o_rd_en = 1'b1;
        o_imm   = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                   i_inst[20], i_inst[30:21], 1'b0};
      end
      default: o_illegal = 1'b1;
    endcase
    if (i_inst[11:7] == 5'd0) o_rd_en = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Handshaked decode stage. Instructions are decoded on the way
//               in and held in a head/skid register pair so that in_ready can
//               be a pure register while still sustaining one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  decode_if.slave  bus
);

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("decode_stage: XLEN must be 32 or 64");
  end
  if (REG_W < 5) begin : g_bad_reg_w
    $error("decode_stage: REG_W must be at least 5");
  end

  buf_state_t r_state;
  logic       r_out_valid;
  logic       r_in_ready;
  dec_entry_t r_head;
  dec_entry_t r_skid;

  fmt_t        w_fmt;
  logic [31:0] w_imm;
  logic        w_rs1_en;
  logic        w_rs2_en;
  logic        w_rd_en;
  logic        w_illegal;
  dec_entry_t  w_new;
  logic        w_accept;
  logic        w_pop;
  logic        w_head_from_in;
  logic        w_head_from_skid;
  logic        w_skid_load;

  imm_gen u_imm_gen (
    .i_inst    (bus.in_inst),
    .o_fmt     (w_fmt),
    .o_imm     (w_imm),
    .o_rs1_en  (w_rs1_en),
    .o_rs2_en  (w_rs2_en),
    .o_rd_en   (w_rd_en),
    .o_illegal (w_illegal)
  );

  // Assemble the entry that would be stored if the offered instruction is taken.
  always_comb begin
    w_new         = '0;
    w_new.inst    = bus.in_inst;
    w_new.pc      = c_PC_W'(bus.in_pc);
    w_new.rs1     = bus.in_inst[19:15];
    w_new.rs2     = bus.in_inst[24:20];
    w_new.rd      = bus.in_inst[11:7];
    w_new.rs1_en  = w_rs1_en;
    w_new.rs2_en  = w_rs2_en;
    w_new.rd_en   = w_rd_en;
    w_new.imm     = w_imm;
    w_new.fmt     = w_fmt;
    w_new.illegal = w_illegal;
  end

  // Handshake events and register load selects; flush suppresses every load.
  always_comb begin
    w_accept         = bus.in_valid & r_in_ready & ~flush;
    w_pop            = r_out_valid & bus.out_ready;
    w_head_from_in   = w_accept & ((r_state == ST_EMPTY) |
                                   ((r_state == ST_ONE) & w_pop));
    w_skid_load      = w_accept & (r_state == ST_ONE) & ~w_pop;
    w_head_from_skid = ~flush & (r_state == ST_TWO) & w_pop;
  end

  // Occupancy FSM with registered out_valid and in_ready. in_ready stays low
  // in reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_pop) begin
            r_state    <= ST_TWO;
            r_in_ready <= 1'b0;
          end else if (!w_accept && w_pop) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Entry data moves only on a load; pops and flushes touch the valid state only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_head_from_in) begin
        r_head <= w_new;
      end else if (w_head_from_skid) begin
        r_head <= r_skid;
      end
      if (w_skid_load) begin
        r_skid <= w_new;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_inst  = r_head.inst;
  assign bus.out_pc    = XLEN'(r_head.pc);
  assign bus.rs1_sel   = REG_W'(r_head.rs1);
  assign bus.rs2_sel   = REG_W'(r_head.rs2);
  assign bus.rd_sel    = REG_W'(r_head.rd);
  assign bus.rs1_en    = r_head.rs1_en;
  assign bus.rs2_en    = r_head.rs2_en;
  assign bus.rd_en     = r_head.rd_en;
  assign bus.imm       = XLEN'($signed(r_head.imm));
  assign bus.fmt       = r_head.fmt;
  assign bus.illegal   = r_head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage. Accepted instructions are
//               decoded by a behavioural model into a queue; a monitor pops
//               and compares on every output handshake. Directed phases cover
//               decode examples, backpressure, flush, async reset and XLEN=64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
  import decode_pkg::*;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam logic [63:0] c_MASK = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                : 64'h0000_0000_FFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic flush64 = 1'b0;
  always #5 clk = ~clk;

  decode_if #(.XLEN(XLEN), .REG_W(REG_W)) bus ();
  decode_if #(.XLEN(64),   .REG_W(REG_W)) bus64 ();

  decode_stage #(.XLEN(XLEN), .REG_W(REG_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  decode_stage #(.XLEN(64), .REG_W(REG_W)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64), .bus(bus64));

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  en;     // {rs1_en, rs2_en, rd_en}
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode written from the format rules with integer arithmetic.
  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
    exp_t   e;
    longint s;
    longint sgn;
    longint imm;
    int     f;
    s   = longint'($signed(w));
    sgn = (s < 0) ? -1 : 0;
    case (w[6:0])
      7'h33:                      f = 0;
      7'h13, 7'h03, 7'h67, 7'h73: f = 1;
      7'h23:                      f = 2;
      7'h63:                      f = 3;
      7'h37, 7'h17:               f = 4;
      7'h6F:                      f = 5;
      default:                    f = 7;
    endcase
    case (f)
      1: imm = s >>> 20;
      2: imm = (s >>> 25) * 32 + longint'(w[11:7]);
      3: imm = sgn * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
               + longint'(w[11:8]) * 2;
      4: imm = (s >>> 12) * 4096;
      5: imm = sgn * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
               + longint'(w[30:21]) * 2;
      default: imm = 0;
    endcase
    e.inst = w;
    e.pc   = pc;
    e.rs1  = w[19:15];
    e.rs2  = w[24:20];
    e.rd   = w[11:7];
    e.en[2] = (f <= 3);
    e.en[1] = (f == 0) || (f == 2) || (f == 3);
    e.en[0] = ((f == 0) || (f == 1) || (f == 4) || (f == 5)) && (w[11:7] != 5'd0);
    e.imm  = 64'(imm);
    e.fmt  = 3'(f);
    e.ill  = (f == 7);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  ops [10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    w = $urandom();
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  task automatic cmp_out(input exp_t e);
    chk("pop_inst",  64'(bus.out_inst), 64'(e.inst));
    chk("pop_pc",    64'(bus.out_pc), e.pc & c_MASK);
    chk("pop_sels",  64'({bus.rs1_sel, bus.rs2_sel, bus.rd_sel}),
                     64'({REG_W'(e.rs1), REG_W'(e.rs2), REG_W'(e.rd)}));
    chk("pop_en",    64'({bus.rs1_en, bus.rs2_en, bus.rd_en}), 64'(e.en));
    chk("pop_imm",   64'(bus.imm), e.imm & c_MASK);
    chk("pop_fmt",   64'(bus.fmt), 64'(e.fmt));
    chk("pop_ill",   64'(bus.illegal), 64'(e.ill));
  endtask

  // Monitor: occupancy, hold stability, pop comparison, flush, capture.
  initial begin
    exp_t        e;
    bit          hold = 1'b0;
    logic [31:0] s_inst;
    logic [63:0] s_pc, s_imm;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (chk_en) begin
          chk("out_valid_occ", 64'(bus.out_valid), 64'(sb.size() != 0));
          chk("in_ready_occ",  64'(bus.in_ready),  64'(sb.size() < 2));
          if (hold) begin
            chk("hold_inst", 64'(bus.out_inst), 64'(s_inst));
            chk("hold_pc",   64'(bus.out_pc), s_pc);
            chk("hold_imm",  64'(bus.imm), s_imm);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pop_unexpected: got inst 0x%h, expected no output (t=%0t)",
                     bus.out_inst, $time);
          end else begin
            e = sb.pop_front();
            cmp_out(e);
          end
        end
        if (flush) sb.delete();
        if (bus.in_valid && bus.in_ready && !flush)
          sb.push_back(model(bus.in_inst, 64'(bus.in_pc)));
        hold   = bus.out_valid && !bus.out_ready && !flush;
        s_inst = bus.out_inst;
        s_pc   = 64'(bus.out_pc);
        s_imm  = 64'(bus.imm);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction (call at posedge+1); returns at posedge+1 after acceptance.
  task automatic send(input logic [31:0] w, input logic [63:0] pc);
    int n;
    bus.in_valid = 1'b1;
    bus.in_inst  = w;
    bus.in_pc    = XLEN'(pc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 100);
    if (!bus.in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [14:0] sels;
    logic [2:0]  en;
    logic        ill;
  } dir_t;

  localparam logic [31:0] c_A = 32'h00A00093;
  localparam logic [31:0] c_B = 32'h002081B3;
  localparam logic [31:0] c_C = 32'h00C0006F;

  initial begin
    dir_t dv [5];
    exp_t e64;
    dv[0] = '{32'hFFF10093, 3'd1, 32'hFFFFFFFF, {5'd2, 5'd31, 5'd1},  3'b101, 1'b0};
    dv[1] = '{32'h00512423, 3'd2, 32'h00000008, {5'd2, 5'd5,  5'd8},  3'b110, 1'b0};
    dv[2] = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, {5'd0, 5'd0,  5'd29}, 3'b110, 1'b0};
    dv[3] = '{32'h00000000, 3'd7, 32'h00000000, {5'd0, 5'd0,  5'd0},  3'b000, 1'b1};
    dv[4] = '{32'h0000006F, 3'd5, 32'h00000000, {5'd0, 5'd0,  5'd0},  3'b000, 1'b0};

    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_inst = '0; bus64.in_pc = '0; bus64.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_inst",  64'(bus.out_inst), 64'd0);
    chk("rst_imm_fmt",   64'({bus.imm, bus.fmt, bus.illegal}), 64'd0);
    chk("rst_en",        64'({bus.rs1_en, bus.rs2_en, bus.rd_en}), 64'd0);
    rst_n = 1'b1;
    sync();
    sync();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk_en = 1'b1;

    // Directed decode examples
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(dv[i].inst, 64'h100 + 64'(4 * i));
      @(negedge clk);
      chk("dir_valid", 64'(bus.out_valid), 64'd1);
      chk("dir_fmt",   64'(bus.fmt), 64'(dv[i].fmt));
      chk("dir_imm",   64'(bus.imm), 64'(dv[i].imm));
      chk("dir_sels",  64'({bus.rs1_sel, bus.rs2_sel, bus.rd_sel}), 64'(dv[i].sels));
      chk("dir_en",    64'({bus.rs1_en, bus.rs2_en, bus.rd_en}), 64'(dv[i].en));
      chk("dir_ill",   64'(bus.illegal), 64'(dv[i].ill));
      if (i == 0) chk("dir_pc", 64'(bus.out_pc), 64'h100);
      sync();
    end

    // XLEN=64 instance: addi x1,x2,-1
    bus64.in_valid = 1'b1;
    bus64.in_inst  = 32'hFFF10093;
    bus64.in_pc    = 64'h0000_0001_0000_0100;
    @(negedge clk);
    chk("x64_in_ready", 64'(bus64.in_ready), 64'd1);
    sync();
    bus64.in_valid = 1'b0;
    @(negedge clk);
    e64 = model(32'hFFF10093, 64'h0000_0001_0000_0100);
    chk("x64_valid", 64'(bus64.out_valid), 64'd1);
    chk("x64_imm",   bus64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("x64_imm_model", bus64.imm, e64.imm);
    chk("x64_pc",    bus64.out_pc, 64'h0000_0001_0000_0100);
    sync();

    // Backpressure: A, B accepted, C held until downstream drains
    bus.out_ready = 1'b0;
    fork
      begin
        send(c_A, 64'h200);
        send(c_B, 64'h204);
        send(c_C, 64'h208);
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_head_A", 64'(bus.out_inst), 64'(c_A));
        sync();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_seq_A", 64'({bus.out_valid, bus.out_inst}), {31'd0, 1'b1, c_A});
        @(negedge clk);
        chk("bp_seq_B", 64'({bus.out_valid, bus.out_inst}), {31'd0, 1'b1, c_B});
        @(negedge clk);
        chk("bp_seq_C", 64'({bus.out_valid, bus.out_inst}), {31'd0, 1'b1, c_C});
      end
    join
    repeat (3) sync();

    // Flush while full, with an instruction offered in the same cycle
    bus.out_ready = 1'b0;
    send(32'h00100113, 64'h300);
    send(32'h00200193, 64'h304);
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h00300213;
    bus.in_pc    = XLEN'(64'h308);
    flush = 1'b1;
    sync();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready",  64'(bus.in_ready), 64'd1);
    sync();
    bus.out_ready = 1'b1;
    repeat (3) sync();
    send(32'h00400293, 64'h30C);
    @(negedge clk);
    chk("post_flush_inst", 64'(bus.out_inst), 64'h00400293);
    sync();

    // Asynchronous reset with a valid entry held
    bus.out_ready = 1'b0;
    send(32'h00500313, 64'h400);
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    chk_en = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_inst",  64'(bus.out_inst), 64'd0);
    chk("arst_out_pc",    64'(bus.out_pc), 64'd0);
    chk("arst_imm_fmt",   64'({bus.imm, bus.fmt, bus.illegal}), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    sync();
    sync();
    chk("arst_ghost_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_in_ready",    64'(bus.in_ready), 64'd1);
    chk_en = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_inst   = rand_inst();
      bus.in_pc     = XLEN'($urandom());
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 49) == 0);
      sync();
    end
    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) sync();
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Parametrised, handshaked instruction-decode pipeline stage sitting between fetch and register-file read/execute. It accepts one 32-bit instruction plus PC per cycle over a valid/ready interface and classifies the instruction format. It produces register selects with per-field enable flags and a sign-extended XLEN immediate, all from registered outputs. A two-entry skid buffer gives full throughput under backpressure, and a synchronous flush discards in-flight instructions on redirect.

## Interface
- XLEN, 32: datapath width of PC and immediate; legal values 32 or 64.
- REG_W, 5: register-select width; instruction fields are fixed 5 bits and are zero-extended to REG_W. REG_W must be ≥ 5.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  drop all held entries at next edge.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts.
- out_inst  out  32  instruction passed through.
- out_pc  out  XLEN  PC passed through.
- rs1_sel, rs2_sel, rd_sel  out  REG_W each  inst[19:15], inst[24:20], inst[11:7].
- rs1_en, rs2_en, rd_en  out  1 each  field used by format; rd_en is also 0 when rd == 0.
- imm  out  XLEN  sign-extended immediate; 0 for R-format and illegal.
- fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- illegal  out  1  opcode not recognised.

## Operation
Decode of in_inst is combinational and is stored with the entry at acceptance. All outputs come from the head entry register.

Opcode (inst[6:0]) to format:
- 0110011 → R.
- 0010011, 0000011, 1100111, 1110011 → I.
- 0100011 → S.
- 1100011 → B.
- 0110111, 0010111 → U.
- 1101111 → J.
- Anything else → ILL, with illegal=1 and all enables 0.

Field enables by format:
- R: rs1, rs2, rd.
- I: rs1, rd.
- S and B: rs1, rs2.
- U and J: rd.

Immediates, each sign-extended from inst[31] to XLEN:
- I: inst[31:20].
- S: {inst[31:25], inst[11:7]}.
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U: {inst[31:12], 12'b0}.
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.

Buffer state machine: head entry (drives outputs) and skid entry.
- EMPTY → ONE: accept.
- ONE → ONE: accept and pop together; head reloads.
- ONE → EMPTY: pop, no accept.
- ONE → TWO: accept, no pop; new entry goes to skid.
- TWO → ONE: pop; skid moves to head. No accept is possible, since in_ready=0.

Events:
- Accept = in_valid && in_ready.
- Pop = out_valid && out_ready.

Flush:
- Next state is EMPTY regardless of other inputs.
- An instruction offered in the same cycle is dropped, even if in_ready=1.
- A pop in the flush cycle still counts downstream.

## Timing
- Reset (async assert): state EMPTY; out_valid=0, in_ready=1 (only once rst_n has deasserted); all data outputs 0; fmt=0, illegal=0, all enables 0.
- Latency: an instruction accepted at edge N is presented with out_valid=1 after edge N. Outputs are valid in cycle N+1.
- Throughput: one per cycle while out_ready=1.
- While out_valid && !out_ready, all outputs hold stable.
- in_ready has no combinational path from out_ready. It deasserts the cycle after the stage enters TWO, and reasserts the cycle after the pop that leaves TWO.
- Data registers update only on load. Valid bits alone clear on pop or flush.
- Reset deassertion mid-stream: the stage restarts in EMPTY with no ghost entry.

## Structure
- Shared package decode_pkg holds:
  - the fmt_t enum (R, I, S, B, U, J, ILL);
  - opcode localparams;
  - the decoded-entry struct (inst, pc, selects, enables, imm, fmt, illegal).
- Sub-module imm_gen (combinational: inst → fmt, imm, enables, illegal) is instantiated once on the input side. The stage wrapper holds the two-entry buffer and the state machine.

## Test plan
- Reset, then in 0xFFF10093 (addi x1,x2,-1), pc 0x100, with out_ready=1 → next cycle:
  - out_valid=1, fmt=I, rs1_sel=2, rd_sel=1, imm=0xFFFFFFFF;
  - rs1_en=1, rs2_en=0, rd_en=1, out_pc=0x100.
- in 0x00512423 (sw x5,8(x2)) → fmt=S, rs1=2, rs2=5, imm=8, rd_en=0. Then 0xFE000EE3 (beq x0,x0,-4) → fmt=B, imm=0xFFFFFFFC.
- in 0x00000000 → illegal=1, fmt=7, imm=0, all enables 0. Then 0x0000006F (jal x0,0) → fmt=J, imm=0, rd_en=0.
- Backpressure: out_ready=0, three back-to-back valid instructions A, B, C.
  - A and B are accepted; in_ready=0 from the cycle after B is accepted; C is held by the source.
  - Raise out_ready → A, B, C emerge in order on consecutive cycles with no loss or duplication.
- Stage in TWO with flush=1 and in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, and the flushed and offered instructions never appear.
- Assert rst_n=0 asynchronously mid-stream with out_valid=1 → out_valid and outputs go to 0 before the next clock edge.
- Run at XLEN=64 → the addi case gives imm=0xFFFFFFFFFFFFFFFF.
